// File: rtl/reg_bus_regfile_pkg.sv
// Shared types and width helpers for the REG_BUS register file.
// All widths derive from the data width so that one package serves every instance.
package reg_bus_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte lanes per data word.
  function automatic int strb_w(input int data_width);
    return data_width / 8;
  endfunction

  // Address bits that select a byte inside one word.
  function automatic int offs_w(input int data_width);
    return (data_width > 8) ? $clog2(data_width / 8) : 0;
  endfunction

  // Register index width; at least one bit even for a single register.
  function automatic int idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/reg_bus_regfile_decode.sv
// Combinational address decode: byte address and direction to register index and error.
// Errors are misalignment, out-of-range index, and bus writes to read-only registers.
module reg_bus_regfile_decode
  import reg_bus_regfile_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic                             write_i,
  output logic [idx_width(NUM_REGS)-1:0]   idx_o,
  output logic                             err_o
);

  localparam int OFFS_N = offs_w(DATA_WIDTH);
  localparam int IDX_W  = idx_width(NUM_REGS);

  logic [ADDR_WIDTH-1:0] word;
  logic                  misaligned;
  logic                  in_range;
  logic                  ro_hit;

  always_comb begin
    word       = addr_i >> OFFS_N;
    misaligned = |(addr_i & ADDR_WIDTH'(strb_w(DATA_WIDTH) - 1));
    in_range   = (word < ADDR_WIDTH'(NUM_REGS));
    idx_o      = word[IDX_W-1:0];
    // The RO lookup is only meaningful once the index is known to be in range.
    ro_hit     = in_range & write_i & RO_MASK[idx_o];
    err_o      = misaligned | ~in_range | ro_hit;
  end

endmodule

// File: rtl/reg_bus_regfile.sv
// REG_BUS responder backed by NUM_REGS registers with byte-strobed bus writes,
// programmable wait states, write pulses and full-word hardware overwrite.
module reg_bus_regfile
  import reg_bus_regfile_pkg::*;
#(
  parameter int                  ADDR_WIDTH  = 32,
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  NUM_REGS    = 4,
  parameter int                  WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH-1:0]          reg_addr_i,
  input  logic                           reg_write_i,
  input  logic [DATA_WIDTH-1:0]          reg_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        reg_wstrb_i,
  input  logic                           reg_valid_i,
  output logic [DATA_WIDTH-1:0]          reg_rdata_o,
  output logic                           reg_error_o,
  output logic                           reg_ready_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o,
  input  logic [NUM_REGS-1:0]            hw_we_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata_i
);

  localparam int STRB_N = strb_w(DATA_WIDTH);
  localparam int IDX_W  = idx_width(NUM_REGS);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic                  enter_resp;
  logic                  commit;

  reg_bus_regfile_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_decode (
    .addr_i  (reg_addr_i),
    .write_i (reg_write_i),
    .idx_o   (dec_idx),
    .err_o   (dec_err)
  );

  // With no wait states IDLE goes straight to RESP so ready lands one cycle after capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reg_valid_i) begin
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (!reg_valid_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      state_d = RESP;
      idx_d   = dec_idx;
      err_d   = dec_err;
      rdata_d = (!reg_write_i && !dec_err) ? reg_q_o[dec_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  assign commit = (state_q == RESP) & reg_valid_i & reg_write_i & ~err_q;

  always_comb begin
    pulse_d = '0;
    if (commit) begin
      pulse_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      pulse_q <= pulse_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic                  bus_hit;
      logic [DATA_WIDTH-1:0] word_q, word_d;

      assign bus_hit = commit && (idx_q == IDX_W'(gi));

      // Hardware supplies the base word; strobed bus bytes win on a same-cycle collision.
      always_comb begin
        word_d = hw_we_i[gi] ? hw_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH] : word_q;
        if (bus_hit) begin
          for (int k = 0; k < STRB_N; k++) begin
            if (reg_wstrb_i[k]) begin
              word_d[k*8 +: 8] = reg_wdata_i[k*8 +: 8];
            end
          end
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          word_q <= '0;
        end else begin
          word_q <= word_d;
        end
      end

      assign reg_q_o[gi*DATA_WIDTH +: DATA_WIDTH] = word_q;
    end
  endgenerate

  assign reg_ready_o = (state_q == RESP);
  assign reg_error_o = err_q;
  assign reg_rdata_o = rdata_q;
  assign wr_pulse_o  = pulse_q;

`ifndef SYNTHESIS
  a_valid_held : assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == WAIT) |-> reg_valid_i)
    else $warning("reg_bus: valid withdrawn before ready, request dropped");

  a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (reg_valid_i && $past(reg_valid_i) && !$past(reg_ready_o))
      |-> $stable({reg_addr_i, reg_write_i, reg_wdata_i, reg_wstrb_i}))
    else $error("reg_bus: request fields changed while valid");
`endif

endmodule

// File: tb/tb_reg_bus_regfile.sv
// Scoreboard bench for reg_bus_regfile: directed cases plus randomized traffic checked
// against a word-array model of the register bank.
module tb_reg_bus_regfile;

  localparam int         AW = 32;
  localparam int         DW = 32;
  localparam int         NR = 4;
  localparam int         WC = 1;
  localparam logic [3:0] RO = 4'b1000;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [AW-1:0]     reg_addr_i = '0;
  logic              reg_write_i = 1'b0;
  logic [DW-1:0]     reg_wdata_i = '0;
  logic [DW/8-1:0]   reg_wstrb_i = '0;
  logic              reg_valid_i = 1'b0;
  logic [DW-1:0]     reg_rdata_o;
  logic              reg_error_o;
  logic              reg_ready_o;
  logic [NR*DW-1:0]  reg_q_o;
  logic [NR-1:0]     wr_pulse_o;
  logic [NR-1:0]     hw_we_i = '0;
  logic [NR*DW-1:0]  hw_wdata_i = '0;

  reg_bus_regfile #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .NUM_REGS    (NR),
    .WAIT_CYCLES (WC),
    .RO_MASK     (RO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .reg_addr_i  (reg_addr_i),
    .reg_write_i (reg_write_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_wstrb_i (reg_wstrb_i),
    .reg_valid_i (reg_valid_i),
    .reg_rdata_o (reg_rdata_o),
    .reg_error_o (reg_error_o),
    .reg_ready_o (reg_ready_o),
    .reg_q_o     (reg_q_o),
    .wr_pulse_o  (wr_pulse_o),
    .hw_we_i     (hw_we_i),
    .hw_wdata_i  (hw_wdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [3:0]  pulse_exp[int];
  logic [31:0] model[NR];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference rules: word-aligned, inside the bank, and not a write to a read-only word.
  function automatic bit exp_err(input logic [31:0] a, input bit w);
    logic [3:0] ro_v;
    ro_v = RO;
    if (a % 4 != 0) return 1'b1;
    if (a / 4 >= NR) return 1'b1;
    return w && ro_v[a[3:2]];
  endfunction

  // Monitor: pops one expectation per ready pulse and checks write pulses every cycle.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      logic [3:0] pexp;
      exp_t       e;
      pexp = pulse_exp.exists(cyc) ? pulse_exp[cyc] : 4'b0;
      chk("wr_pulse", 32'(wr_pulse_o), 32'(pexp));
      if (reg_ready_o) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_ready: got ready=1, expected no response (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          chk({e.tag, "_rdata"}, reg_rdata_o, e.rdata);
          chk({e.tag, "_error"}, 32'(reg_error_o), 32'(e.err));
          chk({e.tag, "_latency"}, 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  // Starts at #1 after a posedge; ends at #1 after the commit edge.
  task automatic txn(input string tag, input logic [31:0] a, input bit w, input logic [31:0] d,
                     input logic [3:0] s, input int hw_idx, input logic [31:0] hwd);
    exp_t e;
    bit   err, seen;
    int   idx;
    err = exp_err(a, w);
    idx = int'(a / 4);
    reg_addr_i  = a;
    reg_write_i = w;
    reg_wdata_i = d;
    reg_wstrb_i = s;
    reg_valid_i = 1'b1;
    e.rdata = (!w && !err) ? model[idx] : 32'h0;
    e.err   = err;
    e.due   = cyc + 1 + WC;
    e.tag   = tag;
    sb_q.push_back(e);
    if (w && !err) pulse_exp[cyc + 2 + WC] = 4'(1 << idx);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_i);
      if (reg_ready_o) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got no ready in 10 cycles, expected ready", tag);
    end
    if (hw_idx >= 0) begin
      hw_we_i[hw_idx] = 1'b1;
      hw_wdata_i[hw_idx*DW +: DW] = hwd;
    end
    @(posedge clk_i);
    if (hw_idx >= 0) model[hw_idx] = hwd;
    if (seen && w && !err) begin
      for (int k = 0; k < 4; k++) begin
        if (s[k]) model[idx][k*8 +: 8] = d[k*8 +: 8];
      end
    end
    #1;
    hw_we_i     = '0;
    reg_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) chk($sformatf("%s_reg%0d", tag, i), reg_q_o[i*DW +: DW], model[i]);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(reg_ready_o), 32'h0);
    chk({tag, "_error"}, 32'(reg_error_o), 32'h0);
    chk({tag, "_rdata"}, reg_rdata_o, 32'h0);
    chk({tag, "_pulse"}, 32'(wr_pulse_o), 32'h0);
    for (int i = 0; i < NR; i++) chk($sformatf("%s_q%0d", tag, i), reg_q_o[i*DW +: DW], 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int          pick;
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("por");
    rst_i = 1'b0;
    idle(2);

    // Partial-strobe write to register 1.
    txn("t2_wr", 32'h4, 1'b1, 32'hDEADBEEF, 4'b0101, -1, '0);
    idle(1);
    chk("t2_reg1", reg_q_o[DW +: DW], 32'h00AD00EF);
    check_regs("t2");

    // Read back, then a back-to-back read of register 0.
    txn("t3_rd4", 32'h4, 1'b0, '0, 4'hF, -1, '0);
    txn("t3_rd0", 32'h0, 1'b0, '0, 4'hF, -1, '0);
    idle(1);

    // Error cases.
    txn("t4_wr_ro", 32'hC, 1'b1, 32'h12345678, 4'hF, -1, '0);
    idle(1);
    txn("t4_rd_oor", 32'h10, 1'b0, '0, 4'hF, -1, '0);
    idle(1);
    txn("t4_rd_mis", 32'h6, 1'b0, '0, 4'hF, -1, '0);
    idle(1);
    check_regs("t4");

    // Bus and hardware write to register 0 in the same cycle.
    txn("t5_coll", 32'h0, 1'b1, 32'h11223344, 4'b0011, 0, 32'hAABBCCDD);
    idle(1);
    chk("t5_reg0", reg_q_o[0 +: DW], 32'hAABB3344);
    check_regs("t5");

    // Reset asserted while the request sits in WAIT.
    reg_addr_i  = 32'h8;
    reg_write_i = 1'b1;
    reg_wdata_i = 32'hCAFEF00D;
    reg_wstrb_i = 4'hF;
    reg_valid_i = 1'b1;
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero("t1_rst");
    reg_valid_i = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle(3);
    check_regs("t1_after");

    // Valid withdrawn during WAIT: no response, then a normal read.
    reg_addr_i  = 32'h0;
    reg_write_i = 1'b0;
    reg_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    reg_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("t6_no_ready", 32'(reg_ready_o), 32'h0);
    end
    idle(1);
    txn("t6_rd0", 32'h0, 1'b0, '0, 4'hF, -1, '0);
    idle(1);

    // Randomized traffic, sometimes back-to-back, occasionally with a hardware collision.
    for (int n = 0; n < 60; n++) begin
      pick = int'($urandom_range(0, 9));
      if (pick <= 4)      a = 32'(4 * pick);
      else if (pick <= 6) a = 32'(4 * $urandom_range(0, 3) + $urandom_range(1, 3));
      else if (pick == 7) a = $urandom;
      else                a = 32'(4 * $urandom_range(0, 3));
      txn($sformatf("rnd%0d", n), a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NR - 1)) : -1, $urandom);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
      if (n % 10 == 9) check_regs($sformatf("rnd%0d", n));
    end

    idle(4);
    check_regs("final");
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
